// File: rtl/trig_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : trig_out_arbiter
// Purpose  : Round-robin arbiter that shares a bank of coax trigger outputs
//            among NREQ requesters. Accepted triggers drive the winner's
//            output mask for pulse_width clocks, followed by a dead time.
//            A prescale decision taken in the grant cycle either fires the
//            trigger or drops it (rejected).
// Ports    : clk_adc        - single clock for all logic
//            reset          - synchronous, active-high reset
//            req/req_en     - per-requester trigger condition and enable
//            req_outmask    - per-requester output mask, [r*NOUT +: NOUT]
//            pulse_width    - pulse length in clocks (0 behaves as 1)
//            dead_time      - idle clocks after each pulse
//            veto           - busy veto, blocks new grants only
//            prescale_pass  - prescale decision for the grant cycle
//            coax_out       - registered trigger outputs
//            grant_valid    - one-cycle strobe per accepted trigger
//            grant_id       - index of the last granted requester
//            last_fired     - grant_id+1 of last accepted trigger, 0 = none
//            fired_count    - accepted trigger count (wraps)
//            rejected_count - prescale-rejected count (wraps)
//            state          - FSM state: IDLE=0, FIRE=1, DEAD=2
// Config   : define TRIG_ARB_COUNTERS_EN to build the monitoring counters;
//            without it fired_count/rejected_count are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module trig_out_arbiter #(
  parameter int NREQ = 8,
  parameter int NOUT = 16,
  parameter int CNTW = 32
) (
  input  logic                 clk_adc,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_en,
  input  logic [NREQ*NOUT-1:0] req_outmask,
  input  logic [7:0]           pulse_width,
  input  logic [7:0]           dead_time,
  input  logic                 veto,
  input  logic                 prescale_pass,
  output logic [NOUT-1:0]      coax_out,
  output logic                 grant_valid,
  output logic [7:0]           grant_id,
  output logic [7:0]           last_fired,
  output logic [CNTW-1:0]      fired_count,
  output logic [CNTW-1:0]      rejected_count,
  output logic [1:0]           state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] C_LAST_REQ = PW'(NREQ - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FIRE = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [PW-1:0]   rr_ptr_q;
  logic [NOUT-1:0] coax_q;
  logic            grant_valid_q;
  logic [7:0]      grant_id_q;
  logic [7:0]      last_fired_q;
  logic [7:0]      width_cnt_q;
  logic [7:0]      dead_cnt_q;

  logic            w_found;
  logic [PW-1:0]   w_win;
  int              w_cand;
  logic            w_decide;
  logic            w_grant;
  logic            w_reject;
  logic            w_fire_end;
  logic            w_dead_end;
  logic [NREQ-1:0] w_clr;
  logic [7:0]      w_pw_eff;

  // Round-robin search: first pending bit at or above rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = int'(rr_ptr_q) + i;
      if (w_cand >= NREQ) begin
        w_cand = w_cand - NREQ;
      end
      if (!w_found && pending_q[w_cand]) begin
        w_found = 1'b1;
        w_win   = PW'(w_cand);
      end
    end
  end

  // Output/control decode from the current state.
  always_comb begin
    w_decide   = (state_q == S_IDLE) && w_found && !veto;
    w_grant    = w_decide && prescale_pass;
    w_reject   = w_decide && !prescale_pass;
    // width_cnt is never loaded below 1, so <= 1 only guards the impossible 0
    w_fire_end = (state_q == S_FIRE) && (width_cnt_q <= 8'd1);
    w_dead_end = (state_q == S_DEAD) && (dead_cnt_q <= 8'd1);
    w_clr      = '0;
    if (w_decide) begin
      w_clr[w_win] = 1'b1;
    end
    w_pw_eff   = (pulse_width == 8'd0) ? 8'd1 : pulse_width;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_grant) begin
          state_d = S_FIRE;
        end
      end
      S_FIRE: begin
        if (w_fire_end) begin
          state_d = (dead_cnt_q == 8'd0) ? S_IDLE : S_DEAD;
        end
      end
      S_DEAD: begin
        if (w_dead_end) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The clear of the served bit wins over a same-cycle re-request, so a
  // requester held high across its grant is not counted twice.
  assign pending_d = (pending_q | (req & req_en)) & ~w_clr;

  // State and datapath registers.
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pending_q     <= '0;
      rr_ptr_q      <= '0;
      coax_q        <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= 8'd0;
      last_fired_q  <= 8'd0;
      width_cnt_q   <= 8'd0;
      dead_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      grant_valid_q <= w_grant;
      if (w_grant) begin
        coax_q       <= req_outmask[int'(w_win)*NOUT +: NOUT];
        width_cnt_q  <= w_pw_eff;
        dead_cnt_q   <= dead_time;
        grant_id_q   <= 8'(w_win);
        last_fired_q <= 8'(w_win) + 8'd1;
        rr_ptr_q     <= (w_win == C_LAST_REQ) ? '0 : w_win + PW'(1);
      end else if (state_q == S_FIRE) begin
        if (w_fire_end) begin
          coax_q      <= '0;
          width_cnt_q <= 8'd0;
        end else begin
          width_cnt_q <= width_cnt_q - 8'd1;
        end
      end else if (state_q == S_DEAD) begin
        dead_cnt_q <= dead_cnt_q - 8'd1;
      end
    end
  end

`ifdef TRIG_ARB_COUNTERS_EN
  logic [CNTW-1:0] fired_cnt_q;
  logic [CNTW-1:0] rejected_cnt_q;

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      fired_cnt_q    <= '0;
      rejected_cnt_q <= '0;
    end else begin
      if (w_grant) begin
        fired_cnt_q <= fired_cnt_q + CNTW'(1);
      end
      if (w_reject) begin
        rejected_cnt_q <= rejected_cnt_q + CNTW'(1);
      end
    end
  end

  assign fired_count    = fired_cnt_q;
  assign rejected_count = rejected_cnt_q;
`else
  assign fired_count    = '0;
  assign rejected_count = '0;
`endif

  assign coax_out    = coax_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign last_fired  = last_fired_q;
  assign state       = state_q;

endmodule
`default_nettype wire
